// File: rtl/int_entry_sequencer.sv
// Interrupt-entry sequencer for the fetch stage.
// Catches a rising edge on the interrupt line and waits for a safe point.
// It then freezes the PC and injects three push pseudo-instructions
// (PC high, PC low, flags) before pulsing the vector load.
module int_entry_sequencer #(
  parameter logic [15:0] PUSH_OPCODE = 16'hF800,
  parameter logic [15:0] NOP_OPCODE  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  // external interrupt request line; "int" is a reserved word in SV
  input  logic        int_req,
  input  logic        stall_control_hazard,
  input  logic        stall_load_usecase,
  input  logic        branch_pending,
  output logic        int_pending,
  output logic        busy,
  output logic        int_stall,
  output logic        inject_enable,
  output logic [15:0] inject_instruction,
  output logic        half_pc_selector,
  output logic        flags_selector,
  output logic        push_flags_pc,
  output logic        start_int
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_HI  = 3'd1,
    PUSH_LO  = 3'd2,
    PUSH_FLG = 3'd3,
    VECTOR   = 3'd4
  } state_t;

  typedef struct packed {
    logic        int_stall;
    logic        inject_enable;
    logic        half_pc_selector;
    logic        flags_selector;
    logic        push_flags_pc;
    logic        start_int;
    logic [15:0] inject_instruction;
  } ctrl_t;

  state_t state, state_nxt;
  ctrl_t  ctrl_q;
  logic   int_q;
  logic   int_edge;
  logic   entry_go;

  // Moore decode of the control bundle for a given state
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    c.inject_instruction = NOP_OPCODE;
    case (s)
      PUSH_HI: begin
        c.int_stall          = 1'b1;
        c.inject_enable      = 1'b1;
        c.push_flags_pc      = 1'b1;
        c.inject_instruction = {PUSH_OPCODE[15:2], 2'b00};
      end
      PUSH_LO: begin
        c.int_stall          = 1'b1;
        c.inject_enable      = 1'b1;
        c.push_flags_pc      = 1'b1;
        c.half_pc_selector   = 1'b1;
        c.inject_instruction = {PUSH_OPCODE[15:2], 2'b01};
      end
      PUSH_FLG: begin
        c.int_stall          = 1'b1;
        c.inject_enable      = 1'b1;
        c.push_flags_pc      = 1'b1;
        c.flags_selector     = 1'b1;
        c.inject_instruction = {PUSH_OPCODE[15:2], 2'b10};
      end
      VECTOR: begin
        c.inject_enable = 1'b1;
        c.start_int     = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  // Edge detect, entry qualification and next-state selection
  always_comb begin
    int_edge  = int_req & ~int_q;
    entry_go  = int_pending & ~stall_control_hazard & ~stall_load_usecase & ~branch_pending;
    state_nxt = state;
    case (state)
      IDLE:     if (entry_go)            state_nxt = PUSH_HI;
      PUSH_HI:  if (!stall_load_usecase) state_nxt = PUSH_LO;
      PUSH_LO:  if (!stall_load_usecase) state_nxt = PUSH_FLG;
      PUSH_FLG: if (!stall_load_usecase) state_nxt = VECTOR;
      VECTOR:                            state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // State, pending latch and outputs; outputs are registered from the
  // decode of the next state so they always match the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      int_q       <= 1'b0;
      int_pending <= 1'b0;
      busy        <= 1'b0;
      ctrl_q      <= decode(IDLE);
    end else begin
      int_q <= int_req;
      if (int_edge)
        int_pending <= 1'b1;
      else if (state == IDLE && entry_go)
        int_pending <= 1'b0;
      state  <= state_nxt;
      busy   <= (state_nxt != IDLE);
      ctrl_q <= decode(state_nxt);
    end
  end

  assign int_stall          = ctrl_q.int_stall;
  assign inject_enable      = ctrl_q.inject_enable;
  assign half_pc_selector   = ctrl_q.half_pc_selector;
  assign flags_selector     = ctrl_q.flags_selector;
  assign push_flags_pc      = ctrl_q.push_flags_pc;
  assign start_int          = ctrl_q.start_int;
  assign inject_instruction = ctrl_q.inject_instruction;

endmodule

// File: tb/tb_int_entry_sequencer.sv
// Directed bench for int_entry_sequencer with hand-computed expectations.
module tb_int_entry_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_req;
  logic        stall_control_hazard;
  logic        stall_load_usecase;
  logic        branch_pending;
  logic        int_pending;
  logic        busy;
  logic        int_stall;
  logic        inject_enable;
  logic [15:0] inject_instruction;
  logic        half_pc_selector;
  logic        flags_selector;
  logic        push_flags_pc;
  logic        start_int;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned n_starts = 0;
  int unsigned s0;

  // expected {busy,int_stall,inject_enable,half,flags,push,start,instr}
  localparam logic [22:0] O_IDLE = {7'b0000000, 16'h0000};
  localparam logic [22:0] O_HI   = {7'b1110010, 16'hF800};
  localparam logic [22:0] O_LO   = {7'b1111010, 16'hF801};
  localparam logic [22:0] O_FLG  = {7'b1110110, 16'hF802};
  localparam logic [22:0] O_VEC  = {7'b1010001, 16'h0000};

  int_entry_sequencer #(
    .PUSH_OPCODE(16'hF800),
    .NOP_OPCODE (16'h0000)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .int_req             (int_req),
    .stall_control_hazard(stall_control_hazard),
    .stall_load_usecase  (stall_load_usecase),
    .branch_pending      (branch_pending),
    .int_pending         (int_pending),
    .busy                (busy),
    .int_stall           (int_stall),
    .inject_enable       (inject_enable),
    .inject_instruction  (inject_instruction),
    .half_pc_selector    (half_pc_selector),
    .flags_selector      (flags_selector),
    .push_flags_pc       (push_flags_pc),
    .start_int           (start_int)
  );

  always #5 clk = ~clk;

  // count vector-load pulses seen by the PC
  always @(posedge clk) if (start_int === 1'b1) n_starts++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic pend, input logic [22:0] outs);
    check(tag,
          {8'h0, int_pending, busy, int_stall, inject_enable, half_pc_selector,
           flags_selector, push_flags_pc, start_int, inject_instruction},
          {8'h0, pend, outs});
  endtask

  initial begin
    rst = 1'b1; int_req = 1'b1;
    stall_control_hazard = 1'b0; stall_load_usecase = 1'b0; branch_pending = 1'b0;

    // reset with int held high; the level is seen as an edge after release
    tick(); chk("rst0", 1'b0, O_IDLE);
    tick(); chk("rst1", 1'b0, O_IDLE);
    rst = 1'b0;
    tick(); chk("rel_pend", 1'b1, O_IDLE);
    tick(); chk("rel_hi", 1'b0, O_HI);
    int_req = 1'b0;
    tick(); chk("rel_lo", 1'b0, O_LO);
    tick(); chk("rel_flg", 1'b0, O_FLG);
    tick(); chk("rel_vec", 1'b0, O_VEC);
    tick(); chk("rel_idle", 1'b0, O_IDLE);

    // single pulse held 3 cycles, no stalls
    s0 = n_starts;
    int_req = 1'b1;
    tick(); chk("p_pend", 1'b1, O_IDLE);
    tick(); chk("p_hi", 1'b0, O_HI);
    tick(); chk("p_lo", 1'b0, O_LO);
    int_req = 1'b0;
    tick(); chk("p_flg", 1'b0, O_FLG);
    tick(); chk("p_vec", 1'b0, O_VEC);
    tick(); chk("p_idle", 1'b0, O_IDLE);
    tick(); chk("p_idle2", 1'b0, O_IDLE);
    check("p_starts", n_starts - s0, 1);

    // deferred by branch_pending, then load-use hold in PUSH_LO
    branch_pending = 1'b1; int_req = 1'b1;
    tick(); chk("d_wait0", 1'b1, O_IDLE);
    tick(); chk("d_wait1", 1'b1, O_IDLE);
    tick(); chk("d_wait2", 1'b1, O_IDLE);
    branch_pending = 1'b0; int_req = 1'b0;
    tick(); chk("d_hi", 1'b0, O_HI);
    branch_pending = 1'b1;  // ignored once busy
    tick(); chk("d_lo", 1'b0, O_LO);
    stall_load_usecase = 1'b1;
    tick(); chk("d_lo_hold1", 1'b0, O_LO);
    tick(); chk("d_lo_hold2", 1'b0, O_LO);
    stall_load_usecase = 1'b0;
    tick(); chk("d_flg", 1'b0, O_FLG);
    tick(); chk("d_vec", 1'b0, O_VEC);
    branch_pending = 1'b0;
    tick(); chk("d_idle", 1'b0, O_IDLE);

    // back-to-back: second edge during PUSH_FLG
    s0 = n_starts;
    int_req = 1'b1;
    tick(); chk("b_pend", 1'b1, O_IDLE);
    tick(); chk("b_hi", 1'b0, O_HI);
    int_req = 1'b0;
    tick(); chk("b_lo", 1'b0, O_LO);
    tick(); chk("b_flg", 1'b0, O_FLG);
    int_req = 1'b1;
    tick(); chk("b_vec", 1'b1, O_VEC);
    int_req = 1'b0;
    tick(); chk("b_idle", 1'b1, O_IDLE);
    tick(); chk("b_hi2", 1'b0, O_HI);
    tick(); chk("b_lo2", 1'b0, O_LO);
    tick(); chk("b_flg2", 1'b0, O_FLG);
    tick(); chk("b_vec2", 1'b0, O_VEC);
    tick(); chk("b_idle2", 1'b0, O_IDLE);
    check("b_starts", n_starts - s0, 2);

    // merge: two edges under control-hazard stall give one entry
    s0 = n_starts;
    stall_control_hazard = 1'b1; int_req = 1'b1;
    tick(); chk("m_pend0", 1'b1, O_IDLE);
    int_req = 1'b0;
    tick(); chk("m_pend1", 1'b1, O_IDLE);
    int_req = 1'b1;
    tick(); chk("m_pend2", 1'b1, O_IDLE);
    int_req = 1'b0;
    tick(); chk("m_pend3", 1'b1, O_IDLE);
    stall_control_hazard = 1'b0;
    tick(); chk("m_hi", 1'b0, O_HI);
    stall_control_hazard = 1'b1;  // ignored once busy
    tick(); chk("m_lo", 1'b0, O_LO);
    tick(); chk("m_flg", 1'b0, O_FLG);
    tick(); chk("m_vec", 1'b0, O_VEC);
    stall_control_hazard = 1'b0;
    tick(); chk("m_idle", 1'b0, O_IDLE);
    tick(); chk("m_idle2", 1'b0, O_IDLE);
    check("m_starts", n_starts - s0, 1);

    // new edge on the same cycle the entry starts keeps int_pending set
    s0 = n_starts;
    int_req = 1'b1;
    tick(); chk("s_pend", 1'b1, O_IDLE);
    int_req = 1'b0; stall_control_hazard = 1'b1;
    tick(); chk("s_wait", 1'b1, O_IDLE);
    stall_control_hazard = 1'b0; int_req = 1'b1;
    tick(); chk("s_hi", 1'b1, O_HI);
    int_req = 1'b0;
    tick(); chk("s_lo", 1'b1, O_LO);
    tick(); chk("s_flg", 1'b1, O_FLG);
    tick(); chk("s_vec", 1'b1, O_VEC);
    tick(); chk("s_idle", 1'b1, O_IDLE);
    tick(); chk("s_hi2", 1'b0, O_HI);
    tick(); chk("s_lo2", 1'b0, O_LO);
    tick(); chk("s_flg2", 1'b0, O_FLG);
    tick(); chk("s_vec2", 1'b0, O_VEC);
    tick(); chk("s_idle2", 1'b0, O_IDLE);
    check("s_starts", n_starts - s0, 2);

    // reset mid-sequence aborts and drops the pending request
    s0 = n_starts;
    int_req = 1'b1;
    tick(); chk("r_pend", 1'b1, O_IDLE);
    tick(); chk("r_hi", 1'b0, O_HI);
    int_req = 1'b0;
    tick(); chk("r_lo", 1'b0, O_LO);
    rst = 1'b1; int_req = 1'b1;
    tick(); chk("r_abort", 1'b0, O_IDLE);
    rst = 1'b0; int_req = 1'b0;
    tick(); chk("r_idle", 1'b0, O_IDLE);
    tick(); chk("r_idle2", 1'b0, O_IDLE);
    tick(); chk("r_idle3", 1'b0, O_IDLE);
    check("r_starts", n_starts - s0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
